// File: rtl/tap_pair_sequencer_if.sv
// Handshake bundle between the tap-pair sequencer and its sample source / pre-adder MAC.
interface tap_pair_sequencer_if #(
    parameter int NUM_TAPS = 16
);
    localparam int AW     = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
    localparam int NPAIRS = (NUM_TAPS + 1) / 2;
    localparam int CW     = (NPAIRS > 2) ? $clog2(NPAIRS) : 1;

    logic          sample_valid;
    logic          pair_ready;
    logic [AW-1:0] wr_ptr;
    logic          busy;
    logic          pair_valid;
    logic [AW-1:0] head_addr;
    logic [AW-1:0] tail_addr;
    logic [CW-1:0] coef_addr;
    logic          center;
    logic          last;
    logic          done;
    logic          overrun;

    modport master (
        output sample_valid, pair_ready,
        input  wr_ptr, busy, pair_valid, head_addr, tail_addr, coef_addr,
               center, last, done, overrun
    );

    modport slave (
        input  sample_valid, pair_ready,
        output wr_ptr, busy, pair_valid, head_addr, tail_addr, coef_addr,
               center, last, done, overrun
    );
endinterface

// File: rtl/tap_pair_sequencer.sv
// Walks a symmetric FIR delay line in (head, tail) sample pairs, one pass per new sample.
// Optional sticky overrun detection is built when TAP_SEQ_OVERRUN_EN is defined.
module tap_pair_sequencer #(
    parameter int NUM_TAPS = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    tap_pair_sequencer_if.slave bus
);
    localparam int AW     = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
    localparam int NPAIRS = (NUM_TAPS + 1) / 2;
    localparam int CW     = (NPAIRS > 2) ? $clog2(NPAIRS) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_TAPS - 1);
    localparam logic [AW-1:0] N_AW      = AW'(NUM_TAPS);
    localparam logic [CW-1:0] LAST_I    = CW'(NPAIRS - 1);
    localparam bit            ODD_LEN   = (NUM_TAPS % 2) == 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] i_q, i_d;

    logic          in_run;
    logic          is_last;
    logic [AW-1:0] i_w;
    logic [AW-1:0] tail_room;
    logic [AW-1:0] wr_ptr_inc;

    assign in_run     = (state_q == RUN);
    assign is_last    = (i_q == LAST_I);
    assign i_w        = AW'(i_q);
    assign wr_ptr_inc = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
    // Distance from base+1 to the top of the line; tail wraps once i reaches it.
    assign tail_room  = LAST_ADDR - base_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        base_d   = base_q;
        i_d      = i_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.sample_valid) begin
                    base_d   = wr_ptr_q;
                    wr_ptr_d = wr_ptr_inc;
                    i_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.pair_ready) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            base_q   <= '0;
            i_q      <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            base_q   <= base_d;
            i_q      <= i_d;
        end
    end

    // Modular arithmetic kept within AW bits: results always land in [0, NUM_TAPS).
    assign bus.head_addr  = base_q - i_w + ((base_q < i_w) ? N_AW : '0);
    assign bus.tail_addr  = (i_w >= tail_room) ? (i_w - tail_room) : (base_q + 1'b1 + i_w);
    assign bus.coef_addr  = i_q;
    assign bus.wr_ptr     = wr_ptr_q;
    assign bus.busy       = in_run;
    assign bus.pair_valid = in_run;
    assign bus.last       = in_run && is_last;
    assign bus.center     = ODD_LEN && in_run && is_last;
    assign bus.done       = (state_q == DONE);

`ifdef TAP_SEQ_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (in_run && bus.sample_valid) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_tap_pair_sequencer.sv
// Bench for tap_pair_sequencer: directed vector table, hand sequences, then random traffic vs a pass model.
module tb_tap_pair_sequencer;
`ifdef TAP_SEQ_OVERRUN_EN
    localparam int OVR_EN = 1;
`else
    localparam int OVR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sv = '0;
    logic [1:0] pr = '0;

    always #5 clk = ~clk;

    tap_pair_sequencer_if #(.NUM_TAPS(16)) bus16 ();
    tap_pair_sequencer_if #(.NUM_TAPS(5))  bus5 ();

    assign bus16.sample_valid = sv[0];
    assign bus16.pair_ready   = pr[0];
    assign bus5.sample_valid  = sv[1];
    assign bus5.pair_ready    = pr[1];

    tap_pair_sequencer #(.NUM_TAPS(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    tap_pair_sequencer #(.NUM_TAPS(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

    typedef struct {
        int pv, busy, done, last, center, ovr, wr, head, tail, coef;
    } obs_t;

    typedef struct {
        int d;
        bit sv, pr;
        int pv, head, tail, coef, last, center, done, wr;
    } vec_t;

    int passed = 0;
    int total  = 0;

    // Reference model: expected beat list of the pass in flight, per DUT.
    bit model_en = 1'b0;
    int m_wr[2], m_idx[2], m_cnt[2], m_done[2], m_ov[2];
    int eb_h[2][128], eb_t[2][128], eb_c[2][128], eb_l[2][128], eb_ce[2][128];

    function automatic int taps(input int d);
        return (d == 0) ? 16 : 5;
    endfunction

    function automatic obs_t get_obs(input int d);
        obs_t o;
        if (d == 0) begin
            o = '{int'(bus16.pair_valid), int'(bus16.busy), int'(bus16.done), int'(bus16.last),
                  int'(bus16.center), int'(bus16.overrun), int'(bus16.wr_ptr),
                  int'(bus16.head_addr), int'(bus16.tail_addr), int'(bus16.coef_addr)};
        end else begin
            o = '{int'(bus5.pair_valid), int'(bus5.busy), int'(bus5.done), int'(bus5.last),
                  int'(bus5.center), int'(bus5.overrun), int'(bus5.wr_ptr),
                  int'(bus5.head_addr), int'(bus5.tail_addr), int'(bus5.coef_addr)};
        end
        return o;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wr[d] = 0; m_idx[d] = 0; m_cnt[d] = 0; m_done[d] = 0; m_ov[d] = 0;
        end
    endtask

    task automatic advance_model(input int d);
        int n, np, act;
        n   = taps(d);
        np  = (n + 1) / 2;
        act = (m_idx[d] < m_cnt[d]) ? 1 : 0;
        m_done[d] = 0;
        if (act != 0 && pr[d]) begin
            m_idx[d]++;
            if (m_idx[d] == m_cnt[d]) m_done[d] = 1;
        end
        if (sv[d]) begin
            if (act == 0) begin
                for (int k = 0; k < np; k++) begin
                    eb_h[d][k]  = (m_wr[d] - k + n) % n;
                    eb_t[d][k]  = (m_wr[d] + 1 + k) % n;
                    eb_c[d][k]  = k;
                    eb_l[d][k]  = (k == np - 1) ? 1 : 0;
                    eb_ce[d][k] = (k == np - 1 && (n % 2) == 1) ? 1 : 0;
                end
                m_idx[d] = 0;
                m_cnt[d] = np;
                m_wr[d]  = (m_wr[d] + 1) % n;
            end else begin
                m_ov[d] = 1;
            end
        end
    endtask

    task automatic check_model(input int d);
        obs_t o;
        int act, k;
        o   = get_obs(d);
        act = (m_idx[d] < m_cnt[d]) ? 1 : 0;
        k   = m_idx[d];
        check($sformatf("rnd%0d_pair_valid", d), o.pv, act);
        check($sformatf("rnd%0d_busy", d), o.busy, act);
        check($sformatf("rnd%0d_done", d), o.done, m_done[d]);
        check($sformatf("rnd%0d_wr_ptr", d), o.wr, m_wr[d]);
        check($sformatf("rnd%0d_overrun", d), o.ovr, OVR_EN * m_ov[d]);
        if (act != 0) begin
            check($sformatf("rnd%0d_head", d), o.head, eb_h[d][k]);
            check($sformatf("rnd%0d_tail", d), o.tail, eb_t[d][k]);
            check($sformatf("rnd%0d_coef", d), o.coef, eb_c[d][k]);
            check($sformatf("rnd%0d_last", d), o.last, eb_l[d][k]);
            check($sformatf("rnd%0d_center", d), o.center, eb_ce[d][k]);
        end else begin
            check($sformatf("rnd%0d_last_idle", d), o.last, 0);
            check($sformatf("rnd%0d_center_idle", d), o.center, 0);
        end
    endtask

    task automatic step();
        if (model_en) begin
            advance_model(0);
            advance_model(1);
        end
        @(posedge clk);
        #1;
        if (model_en) begin
            check_model(0);
            check_model(1);
        end
    endtask

    task automatic do_reset();
        sv = '0;
        pr = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_done(input int d, input string name);
        obs_t o;
        int   n;
        n = 0;
        o = get_obs(d);
        while (o.done == 0 && n < 40) begin
            step();
            o = get_obs(d);
            n++;
        end
        check(name, o.done, 1);
    endtask

    vec_t vecs[18];

    initial begin
        obs_t o;

        //            d sv pr  pv head tail coef last cent done wr
        vecs[0]  = '{0, 1, 1,  1,  0,   1,   0,   0,   0,   0,  1};
        vecs[1]  = '{0, 0, 1,  1, 15,   2,   1,   0,   0,   0,  1};
        vecs[2]  = '{0, 0, 1,  1, 14,   3,   2,   0,   0,   0,  1};
        vecs[3]  = '{0, 0, 0,  1, 14,   3,   2,   0,   0,   0,  1};
        vecs[4]  = '{0, 0, 0,  1, 14,   3,   2,   0,   0,   0,  1};
        vecs[5]  = '{0, 0, 0,  1, 14,   3,   2,   0,   0,   0,  1};
        vecs[6]  = '{0, 0, 1,  1, 13,   4,   3,   0,   0,   0,  1};
        vecs[7]  = '{0, 0, 1,  1, 12,   5,   4,   0,   0,   0,  1};
        vecs[8]  = '{0, 0, 1,  1, 11,   6,   5,   0,   0,   0,  1};
        vecs[9]  = '{0, 0, 1,  1, 10,   7,   6,   0,   0,   0,  1};
        vecs[10] = '{0, 0, 1,  1,  9,   8,   7,   1,   0,   0,  1};
        vecs[11] = '{0, 0, 1,  0, -1,  -1,  -1,   0,   0,   1,  1};
        vecs[12] = '{0, 0, 0,  0, -1,  -1,  -1,   0,   0,   0,  1};
        vecs[13] = '{1, 1, 1,  1,  0,   1,   0,   0,   0,   0,  1};
        vecs[14] = '{1, 0, 1,  1,  4,   2,   1,   0,   0,   0,  1};
        vecs[15] = '{1, 0, 1,  1,  3,   3,   2,   1,   1,   0,  1};
        vecs[16] = '{1, 0, 1,  0, -1,  -1,  -1,   0,   0,   1,  1};
        vecs[17] = '{1, 0, 0,  0, -1,  -1,  -1,   0,   0,   0,  1};

        do_reset();
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            check($sformatf("reset%0d_pair_valid", d), o.pv, 0);
            check($sformatf("reset%0d_busy", d), o.busy, 0);
            check($sformatf("reset%0d_done", d), o.done, 0);
            check($sformatf("reset%0d_wr_ptr", d), o.wr, 0);
            check($sformatf("reset%0d_overrun", d), o.ovr, 0);
        end

        foreach (vecs[r]) begin
            sv = '0;
            pr = '0;
            sv[vecs[r].d] = vecs[r].sv;
            pr[vecs[r].d] = vecs[r].pr;
            step();
            o = get_obs(vecs[r].d);
            check($sformatf("vec%0d_pair_valid", r), o.pv, vecs[r].pv);
            if (vecs[r].head >= 0) check($sformatf("vec%0d_head", r), o.head, vecs[r].head);
            if (vecs[r].tail >= 0) check($sformatf("vec%0d_tail", r), o.tail, vecs[r].tail);
            if (vecs[r].coef >= 0) check($sformatf("vec%0d_coef", r), o.coef, vecs[r].coef);
            check($sformatf("vec%0d_last", r), o.last, vecs[r].last);
            check($sformatf("vec%0d_center", r), o.center, vecs[r].center);
            check($sformatf("vec%0d_done", r), o.done, vecs[r].done);
            check($sformatf("vec%0d_wr_ptr", r), o.wr, vecs[r].wr);
        end
        sv = '0;
        pr = '0;

        // Wrap-around: advance the 16-tap line until wr_ptr sits at 15.
        for (int s = 0; s < 14; s++) begin
            sv[0] = 1'b1;
            pr[0] = 1'b1;
            step();
            sv[0] = 1'b0;
            wait_done(0, $sformatf("wrap_pass%0d_done", s));
        end
        pr[0] = 1'b0;
        step();
        o = get_obs(0);
        check("wrap_wr_before", o.wr, 15);
        sv[0] = 1'b1;
        step();
        sv[0] = 1'b0;
        o = get_obs(0);
        check("wrap_head", o.head, 15);
        check("wrap_tail", o.tail, 0);
        check("wrap_wr_after", o.wr, 0);
        pr[0] = 1'b1;
        wait_done(0, "wrap_final_done");
        pr[0] = 1'b0;

        // Sample arriving mid-pass is dropped; overrun flags it only when built in.
        sv[0] = 1'b1;
        step();
        sv[0] = 1'b1;
        step();
        sv[0] = 1'b0;
        o = get_obs(0);
        check("ovr_head", o.head, 0);
        check("ovr_tail", o.tail, 1);
        check("ovr_coef", o.coef, 0);
        check("ovr_wr", o.wr, 1);
        check("ovr_flag", o.ovr, OVR_EN);
        pr[0] = 1'b1;
        wait_done(0, "ovr_pass_done");
        pr[0] = 1'b0;
        step();
        o = get_obs(0);
        check("ovr_sticky", o.ovr, OVR_EN);
        check("ovr_wr_kept", o.wr, 1);

        // Asynchronous reset at beat 4 of a pass.
        sv[0] = 1'b1;
        step();
        sv[0] = 1'b0;
        pr[0] = 1'b1;
        repeat (4) step();
        o = get_obs(0);
        check("midrst_beat4_coef", o.coef, 4);
        check("midrst_beat4_head", o.head, 13);
        pr[0] = 1'b0;
        rst_n = 1'b0;
        #2;
        o = get_obs(0);
        check("midrst_async_pv", o.pv, 0);
        check("midrst_async_wr", o.wr, 0);
        check("midrst_async_ovr", o.ovr, 0);
        @(posedge clk);
        #1;
        o = get_obs(0);
        check("midrst_held_pv", o.pv, 0);
        #2 rst_n = 1'b1;
        sv[0] = 1'b1;
        step();
        sv[0] = 1'b0;
        o = get_obs(0);
        check("midrst_restart_head", o.head, 0);
        check("midrst_restart_tail", o.tail, 1);
        check("midrst_restart_wr", o.wr, 1);

        // Random traffic on both instances against the pass model.
        do_reset();
        model_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                sv[d] = ($urandom_range(0, 3) == 0);
                pr[d] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        model_en = 1'b0;
        sv = '0;
        pr = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
